button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//  Conditions one raw, bouncy mechanical push-button input into clean, glitch-free signals.
//  Sits directly upstream of the external LED output stage.
//  Sequence: 2-FF synchroniser -> counter debounce -> edge pulses, long-press detect, toggle.
//  LED stage consumes btn_level (follow mode) or led_toggle (latch mode).
// PARAMETERS
//  DEBOUNCE_CYCLES    120_000     consecutive stable cycles to accept a level change (10 ms @ 12 MHz); >=2
//  LONG_PRESS_CYCLES  12_000_000  cycles held (after debounce) before long_pulse (1 s @ 12 MHz); >DEBOUNCE_CYCLES
//  ACTIVE_LOW         0           1: raw pin reads 0 when pressed; inverted before synchroniser output
// PORTS
//  CLK            in   1  system clock, 12 MHz
//  RST            in   1  synchronous, active-high reset
//  button         in   1  raw asynchronous button pin
//  btn_level      out  1  debounced level, 1 = pressed
//  press_pulse    out  1  1-cycle strobe on debounced press
//  release_pulse  out  1  1-cycle strobe on debounced release
//  long_pulse     out  1  1-cycle strobe once per press after LONG_PRESS_CYCLES held
//  led_toggle     out  1  flips on every press_pulse
// BEHAVIOUR
//  Reset:
//   - All outputs 0; sync FFs and stable level = released; counters 0; FSM = IDLE.
//   - RST wins over any pending event in the same cycle.
//   - Reset mid-press: outputs 0 until a fresh debounced press is seen.
//  Sync:
//   - 2 FFs on the (polarity-corrected) button; sync_q is the second stage.
//   - No raw-pin path reaches any output.
//  Debounce counter:
//   - Width $clog2(DEBOUNCE_CYCLES+1).
//   - Increments while sync_q != btn_level.
//   - Clears to 0 on any cycle where sync_q == btn_level (bounce restarts the count).
//   - When it has counted DEBOUNCE_CYCLES consecutive differing cycles: btn_level flips on that edge, counter clears.
//   - Latency: clean raw step -> btn_level change = 2 + DEBOUNCE_CYCLES clocks.
//  FSM states:
//   - IDLE: released, stable. -> PRESS_PEND when sync_q=1.
//   - PRESS_PEND: -> IDLE if sync_q returns 0; -> PRESSED when count completes.
//   - PRESSED: -> LONG_HELD when hold count completes; -> RELEASE_PEND when sync_q=0.
//   - LONG_HELD: -> RELEASE_PEND when sync_q=0.
//   - RELEASE_PEND: -> back to PRESSED/LONG_HELD (whichever was left) if sync_q returns 1; -> IDLE when count completes.
//  Pulses:
//   - Registered, asserted exactly 1 cycle, in the same cycle btn_level first shows the new value.
//   - press_pulse and release_pulse are mutually exclusive.
//  Hold counter:
//   - Width $clog2(LONG_PRESS_CYCLES+1).
//   - Clears on press acceptance; increments each cycle in PRESSED; saturates.
//   - long_pulse fires when it reaches LONG_PRESS_CYCLES; at most once per press.
//   - Release before that threshold: no long_pulse.
//   - Hold counter keeps running during RELEASE_PEND bounce.
//  led_toggle:
//   - Registered; inverts in the cycle after press_pulse.
//   - Never changes on release or long press.
//  Boundaries:
//   - Bounce shorter than DEBOUNCE_CYCLES: no output change at all.
//   - Counters never wrap.
//   - Button held through reset deassert: press accepted after 2 + DEBOUNCE_CYCLES clocks.
// STRUCTURE
//  Shared package button_pkg:
//   - FSM state encoding localparams (IDLE, PRESS_PEND, PRESSED, LONG_HELD, RELEASE_PEND).
//   - Default cycle constants derived from CLK_HZ = 12_000_000.
//  Sub-module sync_2ff: generic 2-flop synchroniser with reset value parameter; reused for other pins.
//  Remainder (counters, FSM, pulse regs) lives in this module.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=0)
//  1. Reset: assert RST 3 cycles with button=1 -> all outputs 0 during reset.
//     After release: btn_level=1 and press_pulse high exactly 1 cycle, 6 clocks later.
//  2. Clean press at t0 -> press_pulse 1 cycle at t0+6, btn_level=1 from t0+6, led_toggle=1 from t0+7.
//     Release at t1 -> release_pulse at t1+6.
//  3. Bounce: button pattern 1,0,1,1,0,1,1,1,1... -> no output change until 4 consecutive synced 1s.
//     Then exactly one press_pulse.
//  4. Glitch: 3-cycle high pulse on button -> btn_level, all pulses, and led_toggle stay 0.
//  5. Long press: hold 30 cycles -> press_pulse, then long_pulse exactly 20 cycles after, only once; release_pulse on release.
//     Hold only 15 cycles -> no long_pulse.
//  6. Three clean presses -> led_toggle sequence 1,0,1.
//     RST asserted mid-hold -> all outputs 0 next cycle, no release_pulse emitted.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioning logic:
// FSM state encodings and default timing derived from the 12 MHz system clock.
package button_pkg;

    localparam int unsigned CLK_HZ                    = 12_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = CLK_HZ / 100;
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = CLK_HZ;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_PRESS_PEND   = 3'd1;
    localparam logic [2:0] ST_PRESSED      = 3'd2;
    localparam logic [2:0] ST_LONG_HELD    = 3'd3;
    localparam logic [2:0] ST_RELEASE_PEND = 3'd4;

    typedef enum logic [2:0] {
        IDLE         = ST_IDLE,
        PRESS_PEND   = ST_PRESS_PEND,
        PRESSED      = ST_PRESSED,
        LONG_HELD    = ST_LONG_HELD,
        RELEASE_PEND = ST_RELEASE_PEND
    } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs,
// with a configurable value loaded on synchronous reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Turns a raw bouncy push-button into a debounced level, press/release/long-press
// strobes and a press-driven toggle for the LED stage.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter bit          ACTIVE_LOW        = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic button,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic led_toggle
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

    btn_state_t        state;
    btn_state_t        state_next;
    logic              sync_q;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic level_differs;
    logic deb_done;
    logic press_accept;
    logic release_accept;
    logic hold_full;
    logic hold_inc;
    logic hold_hit;

    sync_2ff #(
        .RESET_VALUE (1'b0)
    ) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (button ^ ACTIVE_LOW),
        .q   (sync_q)
    );

    // A level change is accepted on the edge that would make the count reach DEBOUNCE_CYCLES.
    assign level_differs  = (sync_q != btn_level);
    assign deb_done       = level_differs && (deb_cnt == DEB_LAST);
    assign press_accept   = deb_done && !btn_level;
    assign release_accept = deb_done && btn_level;

    assign hold_full = (hold_cnt == HOLD_MAX);
    assign hold_inc  = ((state == PRESSED) || (state == RELEASE_PEND)) && !hold_full;
    assign hold_hit  = hold_inc && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (sync_q) state_next = PRESS_PEND;
            end
            PRESS_PEND: begin
                if (!sync_q)           state_next = IDLE;
                else if (press_accept) state_next = PRESSED;
            end
            PRESSED: begin
                if (!sync_q)       state_next = RELEASE_PEND;
                else if (hold_hit) state_next = LONG_HELD;
            end
            LONG_HELD: begin
                if (!sync_q) state_next = RELEASE_PEND;
            end
            RELEASE_PEND: begin
                // A saturated hold count means the long press was already reported.
                if (release_accept) state_next = IDLE;
                else if (sync_q)    state_next = hold_full ? LONG_HELD : PRESSED;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            btn_level     <= 1'b0;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            led_toggle    <= 1'b0;
        end else begin
            state <= state_next;

            if (deb_done || !level_differs) deb_cnt <= '0;
            else                            deb_cnt <= deb_cnt + 1'b1;

            if (deb_done) btn_level <= ~btn_level;

            if (press_accept)  hold_cnt <= '0;
            else if (hold_inc) hold_cnt <= hold_cnt + 1'b1;

            press_pulse   <= press_accept;
            release_pulse <= release_accept;
            long_pulse    <= hold_hit;
            led_toggle    <= led_toggle ^ press_pulse;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: stimulus queues the expected pulse events,
// a negedge monitor pops and compares them whenever a pulse output is high.
module tb_button_debouncer;

    localparam logic [2:0] K_PRESS   = 3'b100;
    localparam logic [2:0] K_RELEASE = 3'b010;
    localparam logic [2:0] K_LONG    = 3'b001;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
    } ev_t;

    logic CLK;
    logic RST;
    logic button;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic led_toggle;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  t0;
    ev_t expq[$];

    button_debouncer #(
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (20),
        .ACTIVE_LOW        (1'b0)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .button        (button),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .led_toggle    (led_toggle)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic b, input int n);
        button = b;
        repeat (n) @(negedge CLK);
    endtask

    task automatic expectEvent(input int c, input logic [2:0] k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        expq.push_back(e);
    endtask

    function automatic logic [4:0] allOutputs();
        return {btn_level, press_pulse, release_pulse, long_pulse, led_toggle};
    endfunction

    // Pulse monitor: every observed strobe must match the oldest queued expectation.
    always @(negedge CLK) begin
        ev_t e;
        if (press_pulse || release_pulse || long_pulse) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse at cycle %0d: got %b, expected none",
                         cyc, {press_pulse, release_pulse, long_pulse});
            end else begin
                e = expq.pop_front();
                checkOutput("pulse_cycle", cyc, e.cyc);
                checkOutput("pulse_kind", {29'd0, press_pulse, release_pulse, long_pulse}, {29'd0, e.kind});
            end
        end
        if (expq.size() > 0 && cyc > expq[0].cyc) begin
            e = expq.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missed_pulse at cycle %0d: got none, expected %b at cycle %0d",
                     cyc, e.kind, e.cyc);
        end
    end

    initial begin
        logic bounce [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic exp_led [3] = '{1'b1, 1'b0, 1'b1};

        // Reset held with the button already pressed
        RST    = 1'b1;
        button = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutput("reset_outputs", allOutputs(), 0);
        end
        t0 = cyc;
        expectEvent(t0 + 6, K_PRESS);
        RST = 1'b0;
        applyStimulus(1'b1, 6);
        checkOutput("held_reset_level", btn_level, 1);
        applyStimulus(1'b1, 1);
        checkOutput("held_reset_toggle", led_toggle, 1);
        t0 = cyc;
        expectEvent(t0 + 6, K_RELEASE);
        applyStimulus(1'b0, 10);
        checkOutput("held_reset_release_level", btn_level, 0);

        // Clean press and release
        t0 = cyc;
        expectEvent(t0 + 6, K_PRESS);
        applyStimulus(1'b1, 5);
        checkOutput("clean_level_before", btn_level, 0);
        applyStimulus(1'b1, 1);
        checkOutput("clean_level_after", btn_level, 1);
        applyStimulus(1'b1, 1);
        checkOutput("clean_toggle", led_toggle, 0);
        applyStimulus(1'b1, 5);
        t0 = cyc;
        expectEvent(t0 + 6, K_RELEASE);
        applyStimulus(1'b0, 5);
        checkOutput("clean_release_before", btn_level, 1);
        applyStimulus(1'b0, 1);
        checkOutput("clean_release_after", btn_level, 0);
        applyStimulus(1'b0, 4);

        // Bouncing press: the last 0 is at offset 4, so the step settles at offset 5
        t0 = cyc;
        expectEvent(t0 + 11, K_PRESS);
        for (int i = 0; i < 9; i++) applyStimulus(bounce[i], 1);
        applyStimulus(1'b1, 1);
        checkOutput("bounce_level_before", btn_level, 0);
        applyStimulus(1'b1, 1);
        checkOutput("bounce_level_after", btn_level, 1);
        applyStimulus(1'b1, 1);
        checkOutput("bounce_toggle", led_toggle, 1);
        t0 = cyc;
        expectEvent(t0 + 6, K_RELEASE);
        applyStimulus(1'b0, 10);

        // Short glitch is rejected
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 10);
        checkOutput("glitch_level", btn_level, 0);
        checkOutput("glitch_toggle", led_toggle, 1);

        // Long press held 30 cycles
        t0 = cyc;
        expectEvent(t0 + 6, K_PRESS);
        expectEvent(t0 + 26, K_LONG);
        expectEvent(t0 + 36, K_RELEASE);
        applyStimulus(1'b1, 30);
        applyStimulus(1'b0, 10);
        checkOutput("long_level", btn_level, 0);
        checkOutput("long_toggle", led_toggle, 0);

        // Held only 15 cycles: no long pulse
        t0 = cyc;
        expectEvent(t0 + 6, K_PRESS);
        expectEvent(t0 + 21, K_RELEASE);
        applyStimulus(1'b1, 15);
        applyStimulus(1'b0, 25);
        checkOutput("short_hold_toggle", led_toggle, 1);

        // Fresh reset, then three presses give toggle sequence 1,0,1
        RST = 1'b1;
        applyStimulus(1'b0, 2);
        checkOutput("reset2_outputs", allOutputs(), 0);
        RST = 1'b0;
        applyStimulus(1'b0, 3);
        for (int k = 0; k < 3; k++) begin
            t0 = cyc;
            expectEvent(t0 + 6, K_PRESS);
            expectEvent(t0 + 16, K_RELEASE);
            applyStimulus(1'b1, 10);
            checkOutput("toggle_sequence", led_toggle, exp_led[k]);
            applyStimulus(1'b0, 10);
        end

        // Reset while the button is held
        t0 = cyc;
        expectEvent(t0 + 6, K_PRESS);
        applyStimulus(1'b1, 10);
        checkOutput("midhold_level", btn_level, 1);
        checkOutput("midhold_toggle", led_toggle, 0);
        RST = 1'b1;
        applyStimulus(1'b1, 1);
        checkOutput("midhold_reset_outputs", allOutputs(), 0);
        applyStimulus(1'b0, 2);
        RST = 1'b0;
        applyStimulus(1'b0, 15);
        checkOutput("after_midhold_outputs", allOutputs(), 0);

        checkOutput("pending_events", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
